mem_test_dp: RTL and testbench

//   Dual-port 1024x16 synchronous RAM with a registered read port per side and a

---
 rtl/mem_test_dp.sv | 45 ++++
 tb/tb_mem_test_dp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_test_dp.sv
// mem_test_dp: dual-port 1024x16 RAM with registered per-port reads and an ab-selected output bus.
// Define MEMTEST_OUT_REG_EN to register the output after the ab mux (2-cycle read latency).
module mem_test_dp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ab,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              we_b,
  output logic [DATA_W-1:0] out
);
  localparam logic [DATA_W-1:0] INIT0 = DATA_W'(3);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] q_a_q, q_b_q, q_a_d, q_b_d, mux;
  // Word 0 is held XOR'd with its power-up value, so an all-zero array reads back mem[0] = 3.
  function automatic logic [DATA_W-1:0] bias(input logic [ADDR_W-1:0] a);
    return (a == '0) ? INIT0 : '0;
  endfunction
  always_comb begin
    q_a_d = reset ? '0 : we_a ? data_a : (mem[addr_a] ^ bias(addr_a));
    q_b_d = reset ? '0 : we_b ? data_b : (mem[addr_b] ^ bias(addr_b));
    mux = ab ? q_b_q : q_a_q;
  end
  // Port B's write is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset && we_a) mem[addr_a] <= data_a ^ bias(addr_a);
    if (!reset && we_b) mem[addr_b] <= data_b ^ bias(addr_b);
    q_a_q <= q_a_d;
    q_b_q <= q_b_d;
  end
`ifdef MEMTEST_OUT_REG_EN
  logic [DATA_W-1:0] out_q, out_d;
  always_comb out_d = reset ? '0 : mux;
  always_ff @(posedge clk) out_q <= out_d;
  assign out = out_q;
`else
  assign out = mux;
`endif
endmodule

// File: tb/tb_mem_test_dp.sv
// tb_mem_test_dp: directed and randomized checks of mem_test_dp against an array-based reference model.
module tb_mem_test_dp;
  logic clk = 0, reset = 0, ab = 0, we_a = 0, we_b = 0;
  logic [9:0] addr_a = 0, addr_b = 0;
  logic [15:0] data_a = 0, data_b = 0;
  logic [15:0] out;
  int checks = 0, errors = 0;
  logic [15:0] m_mem [1024];
  logic [15:0] m_qa = 0, m_qb = 0, m_out = 0;

  mem_test_dp dut (
    .clk(clk), .reset(reset), .ab(ab),
    .addr_a(addr_a), .data_a(data_a), .we_a(we_a),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b),
    .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_out();
`ifdef MEMTEST_OUT_REG_EN
    return m_out;
`else
    return ab ? m_qb : m_qa;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    m_out = reset ? 16'h0 : (ab ? m_qb : m_qa);
    if (reset) begin
      m_qa = 0;
      m_qb = 0;
    end else begin
      m_qa = we_a ? data_a : m_mem[addr_a];
      m_qb = we_b ? data_b : m_mem[addr_b];
      if (we_a) m_mem[addr_a] = data_a;
      if (we_b) m_mem[addr_b] = data_b;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    checks++;
    if (out !== 16'h0) begin errors++; $display("FAIL reset_out got %h exp %h", out, 16'h0); end
    reset = 0; ab = 0; addr_a = 0; we_a = 0;
    tick();
`ifdef MEMTEST_OUT_REG_EN
    tick();
`endif
    checks++;
    if (out !== 16'd3) begin errors++; $display("FAIL powerup_mem0 got %h exp %h", out, 16'd3); end
  endtask

  task automatic test_write_first();
    addr_a = 0; data_a = 5; we_a = 1; ab = 0;
    tick();
    checks++;
    if (out !== 16'd5) begin errors++; $display("FAIL write_first got %h exp %h", out, 16'd5); end
    we_a = 0;
    tick();
    checks++;
    if (out !== 16'd5) begin errors++; $display("FAIL read_after_write got %h exp %h", out, 16'd5); end
  endtask

  task automatic test_two_ports();
    addr_a = 1; we_a = 1; data_a = 5; addr_b = 513; we_b = 1; data_b = 5; ab = 0;
    tick();
    checks++;
    if (out !== 16'd5) begin errors++; $display("FAIL dual_write_a got %h exp %h", out, 16'd5); end
    ab = 1;
    #1;
    checks++;
    if (out !== 16'd5) begin errors++; $display("FAIL dual_write_b_mux got %h exp %h", out, 16'd5); end
    we_a = 0; we_b = 0;
    tick();
    checks++;
    if (out !== 16'd5) begin errors++; $display("FAIL read_513 got %h exp %h", out, 16'd5); end
    ab = 0;
    #1;
    checks++;
    if (out !== 16'd5) begin errors++; $display("FAIL read_1 got %h exp %h", out, 16'd5); end
  endtask

  task automatic test_cross_port();
    addr_a = 7; we_a = 0; addr_b = 7; we_b = 1; data_b = 9; ab = 0;
    tick();
    checks++;
    if (out !== 16'd0) begin errors++; $display("FAIL cross_old got %h exp %h", out, 16'd0); end
    we_b = 0;
    tick();
    checks++;
    if (out !== 16'd9) begin errors++; $display("FAIL cross_new got %h exp %h", out, 16'd9); end
  endtask

  task automatic test_same_addr();
    addr_a = 20; addr_b = 20; data_a = 1; data_b = 2; we_a = 1; we_b = 1; ab = 0;
    tick();
    checks++;
    if (out !== 16'd1) begin errors++; $display("FAIL collide_qa got %h exp %h", out, 16'd1); end
    ab = 1;
    #1;
    checks++;
    if (out !== 16'd2) begin errors++; $display("FAIL collide_qb got %h exp %h", out, 16'd2); end
    we_a = 0; we_b = 0; ab = 0;
    tick();
    checks++;
    if (out !== 16'd2) begin errors++; $display("FAIL collide_stored got %h exp %h", out, 16'd2); end
  endtask

  task automatic test_reset_preserve();
    addr_a = 0; data_a = 16'hABCD; we_a = 1; we_b = 0; ab = 0;
    tick();
    reset = 1; data_a = 16'h1234;
    tick();
    checks++;
    if (out !== 16'h0) begin errors++; $display("FAIL reset_clears got %h exp %h", out, 16'h0); end
    reset = 0; we_a = 0;
    tick();
    checks++;
    if (out !== 16'hABCD) begin errors++; $display("FAIL reset_preserves got %h exp %h", out, 16'hABCD); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      ab = 1'($urandom);
      we_a = 1'($urandom);
      we_b = 1'($urandom);
      addr_a = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
      addr_b = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 7)) : 10'($urandom);
      data_a = 16'($urandom);
      data_b = 16'($urandom);
      tick();
      checks++;
      if (out !== exp_out()) begin errors++; $display("FAIL random_edge i=%0d got %h exp %h", i, out, exp_out()); end
      ab = ~ab;
      #1;
      checks++;
      if (out !== exp_out()) begin errors++; $display("FAIL random_ab i=%0d got %h exp %h", i, out, exp_out()); end
    end
    reset = 0; we_a = 0; we_b = 0;
  endtask

  initial begin
    foreach (m_mem[i]) m_mem[i] = 0;
    m_mem[0] = 16'd3;
    test_reset();
`ifndef MEMTEST_OUT_REG_EN
    test_write_first();
    test_two_ports();
    test_cross_port();
    test_same_addr();
    test_reset_preserve();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
